error_inject_serial: RTL and testbench
======================================

// Module: error_inject_serial
// PURPOSE
//  Serial single-bit error injector for a Hamming(7,4) link. Sits between the serial encoder and decoder.
//  Forwards each strobed data bit and inverts exactly one bit per 7-bit codeword at the position error_pos.
//  error_pos = 0 means pass-through with no error.
// PARAMETERS
//  FRAME_LEN  7  bits per codeword; bit positions run 1..FRAME_LEN
//  POS_W      3  width of error_pos; FRAME_LEN must be <= 2**POS_W-1
// PORTS
//  clk         in   1      system clock; all state updates on its rising edge
//  rst_n       in   1      asynchronous active-low reset
//  d_in        in   1      serial data bit; valid only when strobe_in=1
//  strobe_in   in   1      bit-valid qualifier, sampled on clk (level, one bit per high cycle)
//  error_pos   in   POS_W  bit position to corrupt (1..FRAME_LEN); 0 = no injection
//  d_out       out  1      forwarded bit, possibly inverted
//  strobe_out  out  1      strobe_in delayed by one clk
//  err_flag    out  1      high with strobe_out on the bit that was inverted
//  frame_end   out  1      high with strobe_out on the last bit (position FRAME_LEN) of a codeword
// BEHAVIOUR
//  - Reset (rst_n=0, async): d_out=0, strobe_out=0, err_flag=0, frame_end=0, bit_idx=1, pos_lat=0.
//  - bit_idx (1..FRAME_LEN) gives the position of the next strobed bit.
//  - pos_lat captures error_pos when a strobed bit arrives with bit_idx=1.
//  - The first strobed bit after reset also loads pos_lat.
//  - A strobed bit at any other position uses the already latched value.
//    error_pos changes mid-frame therefore take effect at the next codeword.
//  - Each clk with strobe_in=1:
//    hit = (pos == bit_idx) && (pos != 0)
//    pos = error_pos when bit_idx=1, else pos_lat
//    d_out <= d_in ^ hit; strobe_out <= 1; err_flag <= hit; frame_end <= (bit_idx==FRAME_LEN);
//    bit_idx <= (bit_idx==FRAME_LEN) ? 1 : bit_idx+1.
//  - Each clk with strobe_in=0:
//    strobe_out, err_flag and frame_end <= 0; d_out holds its last value; bit_idx and pos_lat hold.
//  - Latency: one clk from d_in/strobe_in to d_out/strobe_out.
//    Back-to-back strobes give full throughput.
//  - error_pos > FRAME_LEN never matches a position, so the frame passes unmodified.
//  - At most one inverted bit per codeword is guaranteed.
//  - Reset mid-frame discards the partial codeword; counting restarts at position 1.
// STRUCTURE
//  - Shared package: FRAME_LEN and POS_W defaults.
//  - Single flat module with registered outputs; no sub-module.
// TESTING
//  1. Reset: rst_n=0 with strobe toggling -> all outputs 0, bit_idx=1 after release.
//  2. error_pos=0, strobe every clk, d_in=0,0,1,0,1,1,0 -> d_out=0,0,1,0,1,1,0 one clk later; err_flag never set.
//  3. error_pos=3, same data -> d_out=0,0,0,0,1,1,0; err_flag high on the 3rd bit; frame_end high on the 7th bit.
//  4. error_pos=7, two back-to-back frames of all 1s -> bits 7 and 14 come out 0; all other bits are 1.
//  5. Change error_pos 2->5 at bit 4 -> the current frame flips bit 2 only; the next frame flips bit 5.
//  6. Gapped strobes (1 high, 2 low) with error_pos=1 -> only the first strobed bit of each frame is inverted.
//     d_out holds between strobes.

Source files
------------

// File: rtl/error_inject_serial_pkg.sv
// Shared sizing for the Hamming(7,4) serial error injector.
package error_inject_serial_pkg;
    localparam int FRAME_LEN = 7;
    localparam int POS_W     = 3;

    localparam logic [POS_W-1:0] FIRST_POS = POS_W'(1);
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FRAME_LEN);
endpackage

// File: rtl/error_inject_serial_if.sv
// Serial bit stream into and out of the error injector, plus the injection position.
interface error_inject_serial_if;
    import error_inject_serial_pkg::*;

    logic             d_in;
    logic             strobe_in;
    logic [POS_W-1:0] error_pos;
    logic             d_out;
    logic             strobe_out;
    logic             err_flag;
    logic             frame_end;

    modport master (
        output d_in, strobe_in, error_pos,
        input  d_out, strobe_out, err_flag, frame_end
    );

    modport slave (
        input  d_in, strobe_in, error_pos,
        output d_out, strobe_out, err_flag, frame_end
    );
endinterface

// File: rtl/error_inject_serial.sv
// Forwards strobed bits with one clk of latency, inverting at most one bit per codeword.
module error_inject_serial
    import error_inject_serial_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    error_inject_serial_if.slave bus
);

    logic [POS_W-1:0] r_bit_idx;
    logic [POS_W-1:0] r_pos_lat;
    logic [POS_W-1:0] w_pos;
    logic             w_first;
    logic             w_last;
    logic             w_hit;

    // The first bit of a codeword uses error_pos directly so the latch never lags a frame.
    assign w_first = (r_bit_idx == FIRST_POS);
    assign w_last  = (r_bit_idx == LAST_POS);
    assign w_pos   = w_first ? bus.error_pos : r_pos_lat;
    assign w_hit   = (w_pos == r_bit_idx) && (w_pos != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx      <= FIRST_POS;
            r_pos_lat      <= '0;
            bus.d_out      <= 1'b0;
            bus.strobe_out <= 1'b0;
            bus.err_flag   <= 1'b0;
            bus.frame_end  <= 1'b0;
        end else if (bus.strobe_in) begin
            bus.d_out      <= bus.d_in ^ w_hit;
            bus.strobe_out <= 1'b1;
            bus.err_flag   <= w_hit;
            bus.frame_end  <= w_last;
            r_bit_idx      <= w_last ? FIRST_POS : r_bit_idx + POS_W'(1);
            if (w_first) begin
                r_pos_lat <= bus.error_pos;
            end
        end else begin
            bus.strobe_out <= 1'b0;
            bus.err_flag   <= 1'b0;
            bus.frame_end  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_error_inject_serial.sv
// Scoreboard bench for error_inject_serial: directed frames, a mid-frame reset and random traffic.
module tb_error_inject_serial;
    import error_inject_serial_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    error_inject_serial_if bus ();

    error_inject_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic d;
        logic err;
        logic fend;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;
    int   bits_sent;
    int   frame_pos;
    logic exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bits are numbered 1..FRAME_LEN from reset; the frame's position is taken at bit 1.
    function automatic void model_push(input logic d, input int pos);
        int   idx;
        logic hit;
        idx = (bits_sent % FRAME_LEN) + 1;
        if (idx == 1) frame_pos = pos;
        hit = (frame_pos != 0) && (frame_pos == idx);
        sb.push_back('{d: d ^ hit, err: hit, fend: (idx == FRAME_LEN)});
        bits_sent++;
    endfunction

    task automatic send_bit(input logic d, input int pos, input int gap);
        @(posedge clk); #1;
        bus.d_in      = d;
        bus.strobe_in = 1'b1;
        bus.error_pos = pos[POS_W-1:0];
        model_push(d, pos);
        repeat (gap) begin
            @(posedge clk); #1;
            bus.strobe_in = 1'b0;
            bus.d_in      = 1'($urandom);
            bus.error_pos = POS_W'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.strobe_in = 1'b0;
            bus.d_in      = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        sb.delete();
        bits_sent = 0;
        frame_pos = 0;
        exp_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.strobe_in = ~bus.strobe_in;
            bus.d_in      = 1'($urandom);
            bus.error_pos = POS_W'($urandom);
            @(negedge clk);
            check("rst_d_out", bus.d_out, 0);
            check("rst_strobe_out", bus.strobe_out, 0);
            check("rst_err_flag", bus.err_flag, 0);
            check("rst_frame_end", bus.frame_end, 0);
        end
        @(posedge clk); #1;
        bus.strobe_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [6:0] data, input int pos, input int gap);
        for (int i = 6; i >= 0; i--) send_bit(data[i], pos, gap);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.strobe_out) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got strobe_out=1 expected no output at %0t", $time);
                end else begin
                    e_mon = sb.pop_front();
                    check("d_out", bus.d_out, e_mon.d);
                    check("err_flag", bus.err_flag, e_mon.err);
                    check("frame_end", bus.frame_end, e_mon.fend);
                    exp_last = e_mon.d;
                end
            end else begin
                check("hold_d_out", bus.d_out, exp_last);
                check("idle_err_flag", bus.err_flag, 0);
                check("idle_frame_end", bus.frame_end, 0);
            end
        end
    end

    initial begin
        int w;
        int pos;
        rst_n         = 1'b0;
        bus.d_in      = 1'b0;
        bus.strobe_in = 1'b0;
        bus.error_pos = '0;
        bits_sent     = 0;
        frame_pos     = 0;
        exp_last      = 1'b0;

        do_reset();
        idle(2);

        send_frame(7'b0010110, 0, 0);
        send_frame(7'b0010110, 3, 0);
        send_frame(7'b1111111, 7, 0);
        send_frame(7'b1111111, 7, 0);
        idle(2);

        // Position changes from 2 to 5 at bit 4; takes effect on the following frame.
        for (int i = 1; i <= 7; i++) send_bit(1'($urandom), (i < 4) ? 2 : 5, 0);
        send_frame(7'($urandom), 5, 0);
        idle(2);

        send_frame(7'b1010011, 1, 2);
        send_frame(7'b0110100, 1, 2);
        idle(3);

        send_bit(1'b1, 4, 0);
        send_bit(1'b0, 4, 0);
        send_bit(1'b1, 4, 0);
        idle(2);
        do_reset();
        send_frame(7'b1100101, 2, 0);
        idle(2);

        pos = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) pos = $urandom_range(0, 7);
            send_bit(1'($urandom), pos, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        idle(1);

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        check("drain_queue", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
